// File: rtl/video_fx_pkg.sv
// Shared types and constants for the scanline effect block.
// Ports: none (package only).
// Provides the scanline mode encoding and the per-channel colour width.
package video_fx_pkg;

  localparam int COLOR_W = 8;

  // Scanline dimming strength; the encoding matches the sl_mode input pins.
  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_25  = 2'd1,
    SL_50  = 2'd2,
    SL_75  = 2'd3
  } sl_mode_t;

endpackage

// File: rtl/video_dim.sv
// Combinational single-channel scanline dimmer.
// Ports: x_i colour in, mode_i dimming strength, en_i dim this pixel, y_o colour out.
// Zero latency, no flow control; the result is always smaller than or equal to x_i.
module video_dim
  import video_fx_pkg::*;
(
  input  logic [COLOR_W-1:0] x_i,
  input  logic [1:0]         mode_i,
  input  logic               en_i,
  output logic [COLOR_W-1:0] y_o
);

  always_comb begin
    y_o = x_i;
    if (en_i) begin
      case (sl_mode_t'(mode_i))
        SL_25:   y_o = x_i - (x_i >> 2);  // keeps 75 %, cannot underflow
        SL_50:   y_o = x_i >> 1;
        SL_75:   y_o = x_i >> 2;
        default: y_o = x_i;
      endcase
    end
  end

endmodule

// File: rtl/video_scanline_fx.sv
// Post-mixer CRT scanline effect: dims alternate active lines and counts active lines per frame.
// Ports: CLK_VIDEO/reset_n, ce_pix pixel enable, sl_mode/sl_phase controls, r/g/b/hs/vs/de_in pixel
//        stream in; CE_PIXEL, VGA_R/G/B/HS/VS/DE pixel stream out (1 ce_pix later), frame_lines status.
module video_scanline_fx
  import video_fx_pkg::*;
#(
  parameter int LINE_W = 12
) (
  input  logic               CLK_VIDEO,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic [1:0]         sl_mode,
  input  logic               sl_phase,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               de_in,
  output logic               CE_PIXEL,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic [LINE_W-1:0]  frame_lines
);

  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  logic               ce_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               hs_q, vs_q, de_q;
  logic               vs_prev_q, de_prev_q;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0]  frame_lines_q, frame_lines_d;
  logic [1:0]         mode_l_q, mode_l_d;
  logic               phase_l_q, phase_l_d;

  logic               vs_rise, de_fall, dim_en;
  logic [LINE_W-1:0]  line_inc;
  logic [COLOR_W-1:0] r_dim, g_dim, b_dim;

  always_comb begin
    vs_rise  = vs_in & ~vs_prev_q;
    de_fall  = ~de_in & de_prev_q;
    line_inc = (line_cnt_q == LINE_MAX) ? line_cnt_q : line_cnt_q + 1'b1;

    line_cnt_d    = line_cnt_q;
    frame_lines_d = frame_lines_q;
    mode_l_d      = mode_l_q;
    phase_l_d     = phase_l_q;

    if (vs_rise) begin
      // A line ending on the very sample where vsync rises still belongs
      // to the frame being closed, so it is folded into the reported count.
      frame_lines_d = de_fall ? line_inc : line_cnt_q;
      line_cnt_d    = '0;
      mode_l_d      = sl_mode;
      phase_l_d     = sl_phase;
    end else if (de_fall) begin
      line_cnt_d = line_inc;
    end

    // phase 0 dims odd lines (1,3,..), phase 1 dims even lines (0,2,..).
    // Blanking is never touched so the mixer's black passes through.
    dim_en = de_in & (line_cnt_q[0] ^ phase_l_q);
  end

  video_dim u_dim_r (.x_i(r_in), .mode_i(mode_l_q), .en_i(dim_en), .y_o(r_dim));
  video_dim u_dim_g (.x_i(g_in), .mode_i(mode_l_q), .en_i(dim_en), .y_o(g_dim));
  video_dim u_dim_b (.x_i(b_in), .mode_i(mode_l_q), .en_i(dim_en), .y_o(b_dim));

  always_ff @(posedge CLK_VIDEO) begin
    if (!reset_n) begin
      ce_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
      mode_l_q      <= 2'd0;
      phase_l_q     <= 1'b0;
    end else begin
      ce_q <= ce_pix;
      if (ce_pix) begin
        // Colour and sync load together so they can never skew.
        r_q           <= r_dim;
        g_q           <= g_dim;
        b_q           <= b_dim;
        hs_q          <= hs_in;
        vs_q          <= vs_in;
        de_q          <= de_in;
        vs_prev_q     <= vs_in;
        de_prev_q     <= de_in;
        line_cnt_q    <= line_cnt_d;
        frame_lines_q <= frame_lines_d;
        mode_l_q      <= mode_l_d;
        phase_l_q     <= phase_l_d;
      end
    end
  end

  assign CE_PIXEL    = ce_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_DE      = de_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_video_scanline_fx.sv
// Randomised scoreboard bench for video_scanline_fx.
// Stimulus pushes expected pixels from a frame-level reference model; a monitor pops and compares.
// Covers reset, all dim modes/phases, mid-frame mode change, vs/de coincidence, sparse ce_pix.
module tb_video_scanline_fx;

  logic       clk = 1'b0;
  logic       reset_n, ce_pix, sl_phase, hs_in, vs_in, de_in;
  logic [1:0] sl_mode;
  logic [7:0] r_in, g_in, b_in;
  logic       CE_PIXEL, VGA_HS, VGA_VS, VGA_DE;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic [11:0] frame_lines;

  always #5 clk = ~clk;

  video_scanline_fx #(.LINE_W(12)) dut (
    .CLK_VIDEO(clk), .reset_n(reset_n), .ce_pix(ce_pix), .sl_mode(sl_mode), .sl_phase(sl_phase),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .CE_PIXEL(CE_PIXEL), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE), .frame_lines(frame_lines)
  );

  typedef struct {
    logic [7:0]  r, g, b;
    logic        hs, vs, de;
    logic [11:0] fl;
  } exp_t;

  exp_t dq[$];
  bit   cq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: lines completed in the current frame, last frame's total,
  // and the mode/phase captured at the start of the frame.
  int m_lines, m_frame, m_mode;
  bit m_phase, m_vs_prev, m_de_prev;

  int         ce_gap   = 0;
  bit         gap_rand = 0;
  int         col_kind = 0;
  logic [7:0] fix_val  = 8'h00;
  logic [7:0] ramp     = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dimx(input int x, input int mode);
    case (mode)
      1:       return x - x / 4;
      2:       return x / 2;
      3:       return x / 4;
      default: return x;
    endcase
  endfunction

  // Called once per clock, right after the inputs for the next edge are driven.
  task automatic tick();
    exp_t e;
    bit vr, df, dimln;
    cq.push_back(reset_n ? ce_pix : 1'b0);
    if (!reset_n) begin
      m_lines = 0; m_frame = 0; m_mode = 0;
      m_phase = 0; m_vs_prev = 0; m_de_prev = 0;
    end else if (ce_pix) begin
      vr    = vs_in && !m_vs_prev;
      df    = !de_in && m_de_prev;
      dimln = de_in && ((m_lines % 2) != int'(m_phase));
      e.r  = dimln ? 8'(dimx(int'(r_in), m_mode)) : r_in;
      e.g  = dimln ? 8'(dimx(int'(g_in), m_mode)) : g_in;
      e.b  = dimln ? 8'(dimx(int'(b_in), m_mode)) : b_in;
      e.hs = hs_in; e.vs = vs_in; e.de = de_in;
      if (vr) begin
        m_frame = m_lines + (df ? 1 : 0);
        if (m_frame > 4095) m_frame = 4095;
        m_lines = 0;
        m_mode  = int'(sl_mode);
        m_phase = sl_phase;
      end else if (df) begin
        m_lines = (m_lines < 4095) ? m_lines + 1 : 4095;
      end
      m_vs_prev = vs_in;
      m_de_prev = de_in;
      e.fl = 12'(m_frame);
      dq.push_back(e);
    end
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic hs, input logic vs, input logic de);
    int gap;
    @(negedge clk);
    ce_pix = 1'b1; r_in = r; g_in = g; b_in = b; hs_in = hs; vs_in = vs; de_in = de;
    tick();
    gap = gap_rand ? int'($urandom_range(0, 2)) : ce_gap;
    repeat (gap) begin
      @(negedge clk);
      ce_pix = 1'b0;
      tick();
    end
  endtask

  task automatic active_px();
    logic [7:0] r, g, b;
    case (col_kind)
      0: begin r = ramp; g = ramp + 8'd85; b = ~ramp; ramp = ramp + 8'd1; end
      1: begin r = fix_val; g = fix_val; b = fix_val; end
      default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
    endcase
    pix(r, g, b, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic line(input int npix, input int hb);
    for (int i = 0; i < npix; i++) active_px();
    for (int i = 0; i < hb; i++) pix(8'($urandom), 8'($urandom), 8'($urandom), i < 2, 1'b0, 1'b0);
  endtask

  task automatic vsync(input int n);
    for (int i = 0; i < n; i++) pix(8'($urandom), 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) pix(8'($urandom), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame_lines(input string name, input int exp);
    @(posedge clk); #3;
    check(name, 32'(frame_lines), 32'(exp));
  endtask

  // Inputs are left as they are (mid-line if so) while reset is held.
  task automatic do_reset(input int n, input bit ce);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n = 1'b0; ce_pix = ce;
      tick();
      if (i == 0) begin
        @(posedge clk); #3;
        check("rst_ce_pixel", 32'(CE_PIXEL), 0);
        check("rst_r", 32'(VGA_R), 0);
        check("rst_g", 32'(VGA_G), 0);
        check("rst_b", 32'(VGA_B), 0);
        check("rst_hs", 32'(VGA_HS), 0);
        check("rst_vs", 32'(VGA_VS), 0);
        check("rst_de", 32'(VGA_DE), 0);
        check("rst_frame_lines", 32'(frame_lines), 0);
      end
    end
    @(posedge clk); #3;
    reset_n = 1'b1;
  endtask

  // Monitor: every clock after stimulus starts, compare CE_PIXEL; on an
  // expected output pixel, pop the scoreboard and compare the whole pixel.
  initial begin
    exp_t e;
    bit ec;
    forever begin
      @(posedge clk); #2;
      if (cq.size() > 0) begin
        ec = cq.pop_front();
        check("ce_pixel", 32'(CE_PIXEL), 32'(ec));
        if (ec) begin
          if (dq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_underflow: got empty queue expected a pixel at %0t", $time);
          end else begin
            e = dq.pop_front();
            check("vga_r", 32'(VGA_R), 32'(e.r));
            check("vga_g", 32'(VGA_G), 32'(e.g));
            check("vga_b", 32'(VGA_B), 32'(e.b));
            check("vga_hs", 32'(VGA_HS), 32'(e.hs));
            check("vga_vs", 32'(VGA_VS), 32'(e.vs));
            check("vga_de", 32'(VGA_DE), 32'(e.de));
            check("frame_lines", 32'(frame_lines), 32'(e.fl));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; ce_pix = 1'b0; sl_mode = 2'd0; sl_phase = 1'b0;
    r_in = 8'h00; g_in = 8'h00; b_in = 8'h00; hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
    do_reset(3, 1'b1);

    // Mode off: 240 lines of ramp, passes straight through.
    sl_mode = 2'd0; sl_phase = 1'b0; col_kind = 0;
    vsync(3);
    for (int l = 0; l < 240; l++) line(8, 4);
    vsync(3);
    check_frame_lines("t1_frame_lines_240", 240);

    // 50 % on odd lines, irregular pixel enable.
    sl_mode = 2'd2; sl_phase = 1'b0; col_kind = 1; fix_val = 8'hC8; gap_rand = 1;
    vsync(2);
    for (int l = 0; l < 4; l++) line(6, 3);

    // 25 % and 75 % with phase 1 (even lines dimmed).
    sl_mode = 2'd1; sl_phase = 1'b1; fix_val = 8'hFF;
    vsync(2);
    for (int l = 0; l < 4; l++) line(5, 3);
    sl_mode = 2'd3;
    vsync(2);
    for (int l = 0; l < 4; l++) line(5, 3);

    // Mode/phase changes mid-frame take effect only at the next vsync.
    sl_mode = 2'd0; sl_phase = 1'b0; col_kind = 2;
    vsync(2);
    for (int l = 0; l < 2; l++) line(5, 3);
    sl_mode = 2'd3; sl_phase = 1'b1;
    for (int l = 0; l < 3; l++) line(5, 3);
    vsync(2);
    for (int l = 0; l < 3; l++) line(5, 3);

    // Last line's de fall coincides with vsync rise.
    gap_rand = 0; ce_gap = 0; sl_mode = 2'd2; sl_phase = 1'b0;
    vsync(2);
    for (int l = 0; l < 100; l++) line(4, 2);
    line(4, 0);
    vsync(2);
    check_frame_lines("t5_frame_lines_101", 101);
    for (int l = 0; l < 3; l++) line(4, 2);

    // Reset mid-line, then ce_pix on every 4th clock with a partial frame.
    line(2, 0);
    do_reset(3, 1'b1);
    ce_gap = 3;
    line(3, 3);
    for (int l = 0; l < 3; l++) line(4, 3);
    vsync(2);
    check_frame_lines("t6_partial_frame_lines", 4);
    for (int l = 0; l < 3; l++) line(4, 3);
    vsync(2);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      sl_mode  = 2'($urandom_range(0, 3));
      sl_phase = 1'($urandom_range(0, 1));
      gap_rand = 1'($urandom_range(0, 1));
      ce_gap   = int'($urandom_range(0, 3));
      vsync(int'($urandom_range(1, 3)));
      for (int l = 0; l < int'($urandom_range(3, 10)); l++)
        line(int'($urandom_range(2, 6)), int'($urandom_range(0, 3)));
    end
    vsync(2);

    repeat (3) begin
      @(negedge clk);
      ce_pix = 1'b0;
      tick();
    end
    @(posedge clk); #4;
    check("scoreboard_drained", 32'(dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
